serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 in_valid  input  1  operand pair a/b is presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  minuend, two's complement.
REQ-007 b  input  WIDTH  subtrahend, two's complement.
REQ-008 out_valid  output  1  diff/lt/eq/ovf hold a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 diff  output  WIDTH  a - b.
REQ-011 lt  output  1  signed a < b.
REQ-012 eq  output  1  a == b.
REQ-013 ovf  output  1  signed overflow of a - b.

Function
REQ-014 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-016 IDLE: on in_valid && in_ready, latch a and b into shift registers, clear borrow, clear bit counter, go to RUN.
REQ-017 RUN: one bit per cycle, LSB first, via a one-bit full subtractor (x, y, borrow_in -> d, borrow_out); d shifts into diff from the MSB end; the borrow flop updates each cycle.
REQ-018 RUN lasts exactly WIDTH cycles, then DONE; out_valid asserts WIDTH cycles after the accepting edge.
REQ-019 ovf = borrow into MSB XOR borrow out of MSB, captured on the final RUN cycle.
REQ-020 lt = raw diff MSB XOR ovf; eq = 1 iff raw diff is all zeros.
REQ-021 DONE: diff/lt/eq/ovf SHALL stay stable while out_valid && !out_ready; on out_valid && out_ready go to IDLE.
REQ-022 Earliest next accept is the cycle after the output handshake (no overlap); throughput 1 result per WIDTH+2 cycles.
REQ-023 in_valid during RUN/DONE is ignored; a, b need only be stable on the accepting edge.

Reset
REQ-024 rst_n low, including mid-RUN or in DONE, SHALL abort the operation: state IDLE; diff, lt, eq, ovf, out_valid = 0; borrow and counter = 0.
REQ-025 After rst_n deasserts, in_ready = 1 from the first clock edge.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_SAT_EN: when defined and ovf = 1, diff SHALL saturate to max positive if a is non-negative, else min negative; lt, eq, ovf are unchanged.
REQ-027 Without SERIAL_SUBTRACTOR_SAT_EN, diff SHALL be the wrapped WIDTH-bit result.

Structure
REQ-028 Package serial_subtractor_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and a counter-width function ($clog2(WIDTH)).
REQ-029 The one-bit stage SHALL be sub-module full_subtractor (a, b, b_in -> d, b_out), instantiated once.

Verification (WIDTH=8)
REQ-030 a=0x05, b=0x03 -> diff=0x02, lt=0, eq=0, ovf=0; out_valid exactly 8 cycles after accept.
REQ-031 a=0x03, b=0x05 -> diff=0xFE, lt=1, eq=0, ovf=0.
REQ-032 a=0x80, b=0x01 -> ovf=1, lt=1; diff=0x7F without the macro, 0x80 with the macro.
REQ-033 a=0x7F, b=0xFF -> ovf=1, lt=0; diff=0x80 without the macro, 0x7F with the macro.
REQ-034 a=b=0x55 with out_ready held low 5 cycles -> eq=1, diff=0x00, outputs stable, in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-035 rst_n pulsed low after 4 RUN cycles -> out_valid=0 and outputs=0 immediately; after release a=0x10, b=0x20 -> diff=0xF0, lt=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM states and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - b_in, with borrow out. Combinational, no backpressure.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first; result valid WIDTH cycles after accept, held until out_ready.
// One operation in flight (in_ready only in IDLE); define SERIAL_SUBTRACTOR_SAT_EN to saturate diff on overflow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             lt,
  output logic             eq,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_lt;
  logic             r_eq;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_diff_shift;
  logic [WIDTH-1:0] w_diff_final;

  full_subtractor u_fs (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .b_in  (r_borrow),
    .d     (w_d),
    .b_out (w_bout)
  );

  assign w_last       = (r_cnt == CW'(WIDTH - 1));
  assign w_ovf        = r_borrow ^ w_bout;
  assign w_diff_shift = {w_d, r_diff[WIDTH-1:1]};

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // On the last RUN cycle r_a[0] is the minuend's sign bit.
  assign w_diff_final = w_ovf ? (r_a[0] ? SAT_MIN : SAT_MAX) : w_diff_shift;
`else
  assign w_diff_final = w_diff_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff <= w_diff_final;
            r_ovf  <= w_ovf;
            r_lt   <= w_d ^ w_ovf;
            r_eq   <= (w_diff_shift == '0);
          end else begin
            r_diff <= w_diff_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign lt        = r_lt;
  assign eq        = r_eq;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed vector bench for serial_subtractor at WIDTH=8, wrapped or saturating per SERIAL_SUBTRACTOR_SAT_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         lt;
  logic         eq;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .lt        (lt),
    .eq        (eq),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] dw;
    logic [W-1:0] ds;
    logic         lt;
    logic         eq;
    logic         ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one pair, keep in_valid high with junk during RUN, return at #1 after out_valid rises.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, output int lat);
    logic busy_ready;
    busy_ready = 1'b0;
    lat = 0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = ~ta;
    b = ~tb;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
      if (in_ready) busy_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("in_ready_low_in_run", busy_ready, 0);
    chk("in_ready_low_in_done", in_ready, 0);
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_hs_in_ready", in_ready, 1);
    chk("idle_after_hs_out_valid", out_valid, 0);
  endtask

  logic [W-1:0] exp_d;
  logic [W-1:0] hold_d;
  int           lat;

  initial begin
    vecs[0]  = '{8'h05, 8'h03, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 8'hFE, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h80, 8'h01, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{8'h7F, 8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 8'h01, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h7F, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h80, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h01, 8'hFF, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'hFF, 8'h01, 8'hFE, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {lt, eq, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      exp_d = vecs[i].ds;
`else
      exp_d = vecs[i].dw;
`endif
      do_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, W);
      chk($sformatf("v%0d_diff", i), diff, exp_d);
      chk($sformatf("v%0d_lt", i), lt, vecs[i].lt);
      chk($sformatf("v%0d_eq", i), eq, vecs[i].eq);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      handshake();
    end

    // Result held under consumer backpressure.
    do_op(8'h55, 8'h55, lat);
    chk("stall_latency", lat, W);
    hold_d = diff;
    chk("stall_diff", hold_d, 8'h00);
    chk("stall_eq", eq, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_out_valid", k), out_valid, 1);
      chk($sformatf("stall%0d_in_ready", k), in_ready, 0);
      chk($sformatf("stall%0d_diff", k), diff, hold_d);
      chk($sformatf("stall%0d_flags", k), {lt, eq, ovf}, 3'b010);
    end
    handshake();

    // Leave a nonzero result in the output register, then abort a later op mid-RUN.
    do_op(8'h80, 8'h01, lat);
    handshake();
    @(negedge clk);
    a = 8'h7F;
    b = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", diff, 0);
    chk("abort_flags", {lt, eq, ovf}, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    do_op(8'h10, 8'h20, lat);
    chk("post_rst_latency", lat, W);
    chk("post_rst_diff", diff, 8'hF0);
    chk("post_rst_lt", lt, 1);
    chk("post_rst_eq_ovf", {eq, ovf}, 2'b00);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
